// File: rtl/branch_resolve_e_pkg.sv
// Shared branch/jump encodings and widths
// for the RV32I execute-stage resolver.
package rv_branch_pkg;

  localparam int PC_W = 13;

  localparam logic [1:0] PRED_INIT = 2'b01;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JAL       = 2'b01;
  localparam logic [1:0] JALR      = 2'b10;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BEQ     = 3'b001;
  localparam logic [2:0] BNE     = 3'b010;
  localparam logic [2:0] BLT     = 3'b011;
  localparam logic [2:0] BGE     = 3'b100;
  localparam logic [2:0] BLTU    = 3'b101;
  localparam logic [2:0] BGEU    = 3'b110;

endpackage

// File: rtl/branch_resolve_e_if.sv
// E-stage bundle from the D/E register and
// the resolution result sent back upstream.
interface branch_resolve_e_if #(
  parameter int PC_W = rv_branch_pkg::PC_W
);

  logic [1:0]      branch_numberE;
  logic            pred_takenE;
  logic [PC_W-1:0] pcEj;
  logic [31:0]     reg_data1Ej;
  logic [31:0]     reg_data2Ej;
  logic [PC_W-1:0] immEj;
  logic [1:0]      jump_codeEj;
  logic [2:0]      branch_codeEj;
  logic            fail_predict;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output branch_numberE, pred_takenE,
    output pcEj, reg_data1Ej, reg_data2Ej,
    output immEj, jump_codeEj, branch_codeEj,
    input  fail_predict, redirect_pc
  );

  modport slave (
    input  branch_numberE, pred_takenE,
    input  pcEj, reg_data1Ej, reg_data2Ej,
    input  immEj, jump_codeEj, branch_codeEj,
    output fail_predict, redirect_pc
  );

endinterface

// File: rtl/branch_resolve_e_sat_counter2.sv
// 2-bit up/down saturating counter used as
// one direction-predictor entry.
module sat_counter2 #(
  parameter logic [1:0] INIT = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  output logic [1:0] q
);

  // step toward the observed direction, clamp at the ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= INIT;
    end else if (en) begin
      if (up && q != 2'b11) begin
        q <= q + 2'b01;
      end else if (!up && q != 2'b00) begin
        q <= q - 2'b01;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_e.sv
// Execute-stage branch/jump resolution with
// a 4-entry direction predictor and stats.
module branch_resolve_e #(
  parameter int         PC_W      = rv_branch_pkg::PC_W,
  parameter int         CNT_W     = 16,
  parameter logic [1:0] PRED_INIT = rv_branch_pkg::PRED_INIT
) (
  input  logic             CLK,
  input  logic             NRST,
  branch_resolve_e_if.slave e,
  input  logic [1:0]       pred_idxF,
  output logic             pred_takenF,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  import rv_branch_pkg::*;

  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] fall_pc;
  logic [PC_W-1:0] jalr_sum;
  logic [PC_W-1:0] jalr_tgt;
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic            taken;
  logic            br_code_ok;
  logic            jal_v;
  logic            jalr_v;
  logic            br_v;
  logic [1:0]      cnt [4];

  assign br_tgt   = e.pcEj + e.immEj;
  assign fall_pc  = e.pcEj + PC_W'(4);
  assign jalr_sum = e.reg_data1Ej[PC_W-1:0] + e.immEj;
  assign jalr_tgt = {jalr_sum[PC_W-1:1], 1'b0};

  assign eq   = e.reg_data1Ej == e.reg_data2Ej;
  assign lt_s = $signed(e.reg_data1Ej) < $signed(e.reg_data2Ej);
  assign lt_u = e.reg_data1Ej < e.reg_data2Ej;

  // evaluate the branch condition for the E instruction
  always_comb begin
    taken      = 1'b0;
    br_code_ok = 1'b1;
    case (e.branch_codeEj)
      BEQ:     taken = eq;
      BNE:     taken = !eq;
      BLT:     taken = lt_s;
      BGE:     taken = !lt_s;
      BLTU:    taken = lt_u;
      BGEU:    taken = !lt_u;
      default: br_code_ok = 1'b0;
    endcase
  end

  // jumps win over branches; nothing resolves in reset
  assign jalr_v = NRST && e.jump_codeEj == JALR;
  assign jal_v  = NRST && e.jump_codeEj == JAL;
  assign br_v   = NRST && !jal_v && !jalr_v && br_code_ok;

  // pick the redirect and mispredict outcome
  always_comb begin
    e.fail_predict = 1'b0;
    e.redirect_pc  = '0;
    unique case (1'b1)
      jalr_v: begin
        e.fail_predict = 1'b1;
        e.redirect_pc  = jalr_tgt;
      end
      br_v: begin
        e.fail_predict = taken != e.pred_takenE;
        e.redirect_pc  = taken ? br_tgt : fall_pc;
      end
      default: begin
        e.fail_predict = 1'b0;
        e.redirect_pc  = '0;
      end
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_pred
    sat_counter2 #(
      .INIT (PRED_INIT)
    ) u_cnt (
      .clk   (CLK),
      .rst_n (NRST),
      .en    (br_v && e.branch_numberE == 2'(i)),
      .up    (taken),
      .q     (cnt[i])
    );
  end

  assign pred_takenF = cnt[pred_idxF][1];

  // saturating branch and mispredict statistics
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (br_v && branch_count != '1) begin
        branch_count <= branch_count + 1'b1;
      end
      if (e.fail_predict && mispredict_count != '1) begin
        mispredict_count <= mispredict_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_e.sv
// Randomized check of branch_resolve_e against
// a behavioural predictor/resolution model.
module tb_branch_resolve_e;

  localparam int PW = 13;

  logic        CLK = 1'b0;
  logic        NRST = 1'b0;
  logic [1:0]  pred_idxF;
  logic        pred_takenF;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  int n_tests = 0;
  int n_fail  = 0;

  int pred [4];
  int m_br;
  int m_mis;

  always #5 CLK = ~CLK;

  branch_resolve_e_if #(.PC_W(PW)) bif ();

  branch_resolve_e dut (
    .CLK              (CLK),
    .NRST             (NRST),
    .e                (bif),
    .pred_idxF        (pred_idxF),
    .pred_takenF      (pred_takenF),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) pred[i] = 1;
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic drive(
    input logic        rst,
    input logic [1:0]  jc,
    input logic [2:0]  bc,
    input logic [1:0]  bn,
    input logic        pt,
    input logic [12:0] pc,
    input logic [31:0] r1,
    input logic [31:0] r2,
    input logic [12:0] imm,
    input logic [1:0]  idx
  );
    NRST                 = rst;
    bif.jump_codeEj      = jc;
    bif.branch_codeEj    = bc;
    bif.branch_numberE   = bn;
    bif.pred_takenE      = pt;
    bif.pcEj             = pc;
    bif.reg_data1Ej      = r1;
    bif.reg_data2Ej      = r2;
    bif.immEj            = imm;
    pred_idxF            = idx;
    if (!rst) model_reset();
  endtask

  task automatic model(
    output bit f,
    output int rd,
    output bit isbr,
    output bit tk
  );
    logic [31:0] r1;
    logic [31:0] r2;
    int pc;
    int imm;
    int bc;
    int jc;
    r1   = bif.reg_data1Ej;
    r2   = bif.reg_data2Ej;
    pc   = int'(bif.pcEj);
    imm  = int'(bif.immEj);
    bc   = int'(bif.branch_codeEj);
    jc   = int'(bif.jump_codeEj);
    f    = 0;
    rd   = 0;
    isbr = 0;
    tk   = 0;
    if (!NRST) begin
      f = 0;
    end else if (jc == 2) begin
      f  = 1;
      rd = (int'(r1 % 8192) + imm) % 8192;
      rd = rd - rd % 2;
    end else if (jc == 1) begin
      f = 0;
    end else if (bc >= 1 && bc <= 6) begin
      isbr = 1;
      case (bc)
        1: tk = r1 == r2;
        2: tk = r1 != r2;
        3: tk = int'(r1) < int'(r2);
        4: tk = int'(r1) >= int'(r2);
        5: tk = r1 < r2;
        default: tk = r1 >= r2;
      endcase
      f  = tk != bif.pred_takenE;
      rd = tk ? (pc + imm) % 8192 : (pc + 4) % 8192;
    end
  endtask

  task automatic cycle();
    bit f;
    bit isbr;
    bit tk;
    int rd;
    int bn;
    @(negedge CLK);
    model(f, rd, isbr, tk);
    chk("fail_predict", 32'(bif.fail_predict), 32'(f));
    chk("redirect_pc", 32'(bif.redirect_pc), 32'(rd));
    chk("pred_takenF", 32'(pred_takenF), 32'(pred[pred_idxF] >= 2));
    chk("branch_count", 32'(branch_count), 32'(m_br));
    chk("mispredict_count", 32'(mispredict_count), 32'(m_mis));
    bn = int'(bif.branch_numberE);
    @(posedge CLK);
    if (NRST) begin
      if (isbr) begin
        if (tk && pred[bn] < 3) pred[bn]++;
        if (!tk && pred[bn] > 0) pred[bn]--;
        if (m_br < 65535) m_br++;
      end
      if (f && m_mis < 65535) m_mis++;
    end
    #1;
  endtask

  initial begin
    model_reset();
    drive(0, 2'd0, 3'd1, 2'd0, 0, 13'h0, 32'd5, 32'd5, 13'h0, 2'd0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_fail", 32'(bif.fail_predict), 32'd0);
    chk("rst_redir", 32'(bif.redirect_pc), 32'd0);
    drive(1, 2'd0, 3'd0, 2'd0, 0, 13'h0, 32'd0, 32'd0, 13'h0, 2'd0);
    cycle();

    drive(1, 2'd0, 3'd1, 2'd1, 0, 13'h100, 32'd5, 32'd5, 13'h020, 2'd1);
    #2;
    chk("beq_fail", 32'(bif.fail_predict), 32'd1);
    chk("beq_redir", 32'(bif.redirect_pc), 32'h120);
    cycle();
    drive(1, 2'd0, 3'd0, 2'd0, 0, 13'h0, 32'd0, 32'd0, 13'h0, 2'd1);
    #2;
    chk("beq_predF", 32'(pred_takenF), 32'd1);
    chk("beq_bcnt", 32'(branch_count), 32'd1);
    chk("beq_mcnt", 32'(mispredict_count), 32'd1);
    cycle();

    drive(1, 2'd0, 3'd3, 2'd0, 1, 13'h200, 32'hFFFFFFFF, 32'd1,
          13'h040, 2'd0);
    #2;
    chk("blt_fail", 32'(bif.fail_predict), 32'd0);
    cycle();
    drive(1, 2'd0, 3'd5, 2'd0, 1, 13'h200, 32'hFFFFFFFF, 32'd1,
          13'h040, 2'd0);
    #2;
    chk("bltu_fail", 32'(bif.fail_predict), 32'd1);
    chk("bltu_redir", 32'(bif.redirect_pc), 32'h204);
    cycle();

    drive(1, 2'd2, 3'd0, 2'd3, 0, 13'h300, 32'h1FFF, 32'd0,
          13'h003, 2'd3);
    #2;
    chk("jalr_fail", 32'(bif.fail_predict), 32'd1);
    chk("jalr_redir", 32'(bif.redirect_pc), 32'h2);
    cycle();
    drive(1, 2'd1, 3'd1, 2'd3, 0, 13'h300, 32'd7, 32'd7,
          13'h010, 2'd3);
    #2;
    chk("jal_fail", 32'(bif.fail_predict), 32'd0);
    cycle();

    for (int i = 0; i < 4; i++) begin
      drive(1, 2'd0, 3'd2, 2'd2, 1'($urandom), 13'h80, 32'd1, 32'd2,
            13'h8, 2'd2);
      cycle();
    end
    drive(1, 2'd0, 3'd0, 2'd0, 0, 13'h0, 32'd0, 32'd0, 13'h0, 2'd2);
    #2;
    chk("sat_hi_predF", 32'(pred_takenF), 32'd1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'd0, 3'd2, 2'd2, 1'($urandom), 13'h80, 32'd9, 32'd9,
            13'h8, 2'd2);
      cycle();
    end
    drive(1, 2'd0, 3'd0, 2'd0, 0, 13'h0, 32'd0, 32'd0, 13'h0, 2'd2);
    #2;
    chk("sat_lo_predF", 32'(pred_takenF), 32'd0);
    cycle();

    drive(1, 2'd0, 3'd0, 2'd1, 1, 13'h1ABC, $urandom, $urandom,
          13'h0F0, 2'd1);
    cycle();
    drive(1, 2'd3, 3'd7, 2'd1, 1, 13'h1ABC, $urandom, $urandom,
          13'h0F0, 2'd1);
    #2;
    chk("rsvd_fail", 32'(bif.fail_predict), 32'd0);
    cycle();

    drive(0, 2'd0, 3'd1, 2'd0, 0, 13'h10, 32'd3, 32'd3, 13'h4, 2'd0);
    #2;
    chk("midrst_fail", 32'(bif.fail_predict), 32'd0);
    chk("midrst_bcnt", 32'(branch_count), 32'd0);
    cycle();

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  jc;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 1) == 0) b = a ^ 32'h8000_0000;
      jc = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'd0;
      drive(($urandom_range(0, 60) != 0), jc, 3'($urandom), 2'($urandom),
            1'($urandom), 13'($urandom), a, b, 13'($urandom),
            2'($urandom));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_e.md
Name: branch_resolve_e

Overview:
- Execute-stage branch/jump resolution unit for the RV32I pipeline.
- Consumes the E-side outputs of the decode/execute calc-pc register: pc, rs1/rs2 data, imm, jump/branch codes, branch number, predicted direction.
- Evaluates the condition and computes the target; raises fail_predict and the redirect PC back to fetch and to the D/E register.
- Owns the 4-entry 2-bit saturating direction predictor that fetch reads, plus branch/mispredict statistics counters.

Parameters:
- PC_W, 13, PC / imm / target width (byte address).
- CNT_W, 16, width of the statistics counters.
- PRED_INIT, 2'b01, reset value of every predictor counter (weakly not-taken).

Ports:
- CLK  input  1  clock.
- NRST  input  1  reset; asynchronous, active-low.
- branch_numberE  input  2  predictor entry index of the E instruction.
- pred_takenE  input  1  direction fetch predicted for the E instruction.
- pcEj  input  PC_W  PC of the E instruction.
- reg_data1Ej  input  32  rs1 value.
- reg_data2Ej  input  32  rs2 value.
- immEj  input  PC_W  branch/jump offset.
- jump_codeEj  input  2  00 none, 01 JAL, 10 JALR, 11 reserved (treated as none).
- branch_codeEj  input  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 reserved (treated as none).
- pred_idxF  input  2  fetch-side predictor lookup index.
- pred_takenF  output  1  MSB of the addressed counter.
- fail_predict  output  1  misprediction; flush D and D/E.
- redirect_pc  output  PC_W  correct next PC when fail_predict = 1.
- branch_count  output  CNT_W  resolved conditional branches.
- mispredict_count  output  CNT_W  fail_predict cycles.

Behaviour:
- Reset (NRST = 0, asynchronous):
  - All predictor counters go to PRED_INIT.
  - branch_count and mispredict_count go to 0.
  - fail_predict = 0 and redirect_pc = 0. These are combinational but must be 0 whenever NRST is low.
- Resolution is combinational from the E-stage inputs, with zero added latency.
  - The inputs come from flops, so there is no combinational loop through fail_predict into the D/E register.
- Condition evaluation:
  - BLT and BGE use a 32-bit signed compare.
  - BLTU and BGEU use an unsigned compare.
  - BEQ and BNE use an equality compare.
- Target arithmetic (all sums are PC_W bits and wrap modulo 2^PC_W; no overflow flag):
  - Branch target = pcEj + immEj.
  - JAL target = pcEj + immEj.
  - JALR target = (reg_data1Ej[PC_W-1:0] + immEj) with bit 0 cleared.
  - Fall-through = pcEj + 4.
- fail_predict rules:
  - Conditional branch: fail_predict = (taken != pred_takenE). redirect_pc = target if taken, else fall-through.
  - JAL: fetch/decode always redirect it correctly, so fail_predict = 0.
  - JALR: fail_predict = 1 unconditionally; redirect_pc = JALR target.
  - Bubble (both codes none or reserved): fail_predict = 0, redirect_pc = 0.
  - If both codes are non-zero (illegal), jump_codeEj takes priority and branch_codeEj is ignored.
- Predictor update (posedge CLK) is applied to conditional branches only:
  - Taken: counter[branch_numberE] increments, saturating at 2'b11.
  - Not taken: counter[branch_numberE] decrements, saturating at 2'b00.
  - Jumps and bubbles never touch the counters.
- Predictor read: pred_takenF = counter[pred_idxF][1] of the current registered state. No bypass; an update becomes visible the cycle after it is made.
- Statistics (posedge CLK), both saturating at all-ones:
  - branch_count increments on every conditional branch in E.
  - mispredict_count increments on every cycle with fail_predict = 1.
- Back-to-back resolution: every E-cycle holding a valid code is resolved and counted exactly once. The D/E register injects a bubble on the cycle after fail_predict or stall, so the block needs no extra squash state.
- Reset during operation: counters and statistics return to their reset values immediately. A branch in E while NRST = 0 produces no update and no fail_predict.

Decomposition:
- Shared package rv_branch_pkg holds:
  - the JUMP_NONE/JAL/JALR and BR_NONE/BEQ/BNE/BLT/BGE/BLTU/BGEU encodings;
  - PC_W;
  - the PRED_INIT constant.
- One sub-module, sat_counter2: a 2-bit up/down saturating counter with enable, direction and async active-low reset. It is instantiated four times.
- Condition compare, target adders and statistics stay in the top level.

Test Plan:
- Reset: NRST = 0 mid-run with BEQ valid in E -> fail_predict = 0, all counters = 01, pred_takenF = 0, both statistics = 0.
- BEQ, rs1 = rs2 = 5, pc = 0x100, imm = 0x020, pred_takenE = 0 -> fail_predict = 1, redirect_pc = 0x120. Next cycle: counter[branch_numberE] = 10, pred_takenF = 1 for that index, branch_count = 1, mispredict_count = 1.
- BLT, rs1 = 0xFFFFFFFF, rs2 = 1, pred_takenE = 1 -> taken and fail_predict = 0. Same operands with BLTU and pred_takenE = 1 -> not taken, fail_predict = 1, redirect_pc = pc + 4.
- JALR, rs1 = 0x1FFF, imm = 0x003 -> redirect_pc = 0x0002 (wrap, bit 0 cleared), fail_predict = 1, counters unchanged. JAL -> fail_predict = 0.
- Saturation: 4 consecutive taken BNE on index 2 -> counter stays at 11. Then 5 not-taken -> counter 00. pred_takenF tracks the counter MSB with one-cycle visibility.
- Bubble cycles with both codes 00 and garbage data -> fail_predict = 0, no counter or statistics change. Reserved codes (jump 11, branch 111) behave identically.
